// File: rtl/iterative_muldiv.sv
// Multi-cycle unsigned multiply / divide unit between register-file read and writeback.
// One radix-2 iteration per clock (shift-add or restoring divide), then one writeback cycle.
module iterative_muldiv #(
  parameter int DataWidth = 16,
  parameter int AddWidth  = 3
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 OP,
  input  logic [DataWidth-1:0] A,
  input  logic [DataWidth-1:0] B,
  input  logic [AddWidth-1:0]  DEST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 WEN,
  output logic [AddWidth-1:0]  WADD,
  output logic [DataWidth-1:0] DATAOUT,
  output logic [DataWidth-1:0] HI,
  output logic                 DIVZ
);

  // state | meaning
  // IDLE  | waiting for START, outputs hold last result
  // RUN   | one shift-add / restoring-divide iteration per clock
  // WB    | single writeback cycle, WEN = DONE = 1
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam int CW = (DataWidth > 2) ? $clog2(DataWidth) : 1;

  state_t                 state;
  logic   [CW-1:0]        counter;
  logic                   op_q;
  logic                   divz_q;
  logic   [AddWidth-1:0]  dest_q;
  logic   [DataWidth-1:0] opnd;
  logic   [DataWidth-1:0] hi_acc;
  logic   [DataWidth-1:0] lo_acc;

  logic   [DataWidth:0]   sum;
  logic   [DataWidth:0]   rem_shift;
  logic   [DataWidth:0]   diff;
  logic   [DataWidth-1:0] next_hi;
  logic   [DataWidth-1:0] next_lo;

  // hi_acc/lo_acc hold {partial product, multiplier} or {remainder, dividend/quotient}.
  // A zero divisor never borrows, so the engine itself yields all-ones and remainder = A.
  always_comb begin
    sum       = '0;
    rem_shift = '0;
    diff      = '0;
    next_hi   = hi_acc;
    next_lo   = lo_acc;
    if (!op_q) begin
      sum     = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
      next_hi = sum[DataWidth:1];
      next_lo = {sum[0], lo_acc[DataWidth-1:1]};
    end else begin
      rem_shift = {hi_acc, lo_acc[DataWidth-1]};
      diff      = rem_shift - {1'b0, opnd};
      if (!diff[DataWidth]) begin
        next_hi = diff[DataWidth-1:0];
        next_lo = {lo_acc[DataWidth-2:0], 1'b1};
      end else begin
        next_hi = rem_shift[DataWidth-1:0];
        next_lo = {lo_acc[DataWidth-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      counter <= '0;
      op_q    <= 1'b0;
      divz_q  <= 1'b0;
      dest_q  <= '0;
      opnd    <= '0;
      hi_acc  <= '0;
      lo_acc  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      WEN     <= 1'b0;
      WADD    <= '0;
      DATAOUT <= '0;
      HI      <= '0;
      DIVZ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            op_q    <= OP;
            dest_q  <= DEST;
            opnd    <= OP ? B : A;
            lo_acc  <= OP ? A : B;
            hi_acc  <= '0;
            divz_q  <= OP && (B == '0);
            counter <= '0;
            BUSY    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          hi_acc <= next_hi;
          lo_acc <= next_lo;
          if (counter == CW'(DataWidth - 1)) begin
            state   <= WB;
            WEN     <= 1'b1;
            DONE    <= 1'b1;
            WADD    <= dest_q;
            DATAOUT <= next_lo;
            HI      <= next_hi;
            DIVZ    <= divz_q;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        WB: begin
          WEN   <= 1'b0;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          WEN   <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv: directed operations push expected writes,
// a negedge monitor pops and checks each register-file write.
module tb_iterative_muldiv;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          START;
  logic          OP;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [AW-1:0] DEST;
  logic          BUSY;
  logic          DONE;
  logic          WEN;
  logic [AW-1:0] WADD;
  logic [DW-1:0] DATAOUT;
  logic [DW-1:0] HI;
  logic          DIVZ;

  iterative_muldiv #(.DataWidth(DW), .AddWidth(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .A(A), .B(B), .DEST(DEST),
    .BUSY(BUSY), .DONE(DONE), .WEN(WEN), .WADD(WADD), .DATAOUT(DATAOUT), .HI(HI), .DIVZ(DIVZ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          divz;
    int            acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_wen_cyc = 0;
  int   prev_wen_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (WEN === 1'b1) begin
      prev_wen_cyc = last_wen_cyc;
      last_wen_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_write", {29'd0, WADD}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("wadd",    {29'd0, WADD},    {29'd0, e.dest});
        chk("dataout", {16'd0, DATAOUT}, {16'd0, e.lo});
        chk("hi",      {16'd0, HI},      {16'd0, e.hi});
        chk("divz",    {31'd0, DIVZ},    {31'd0, e.divz});
        chk("done",    {31'd0, DONE},    32'd1);
        chk("busy_wb", {31'd0, BUSY},    32'd1);
        chk("latency", cyc - e.acc_cyc,  DW);
      end
    end else if (DONE === 1'b1) begin
      chk("done_without_wen", {31'd0, DONE}, 32'd0);
    end
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [AW-1:0] dest);
    OP = op; A = a; B = b; DEST = dest; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = 16'h5A5A; B = 16'hA5A5; DEST = ~dest; OP = ~op;
  endtask

  task automatic issue(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] dest, input logic [DW-1:0] lo,
                       input logic [DW-1:0] hi, input logic divz);
    exp_t e;
    launch(op, a, b, dest);
    e.dest = dest; e.lo = lo; e.hi = hi; e.divz = divz; e.acc_cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (BUSY !== 1'b0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    chk("idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; START = 1'b0; OP = 1'b0; A = '0; B = '0; DEST = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("rst_busy",    {31'd0, BUSY},    32'd0);
    chk("rst_done",    {31'd0, DONE},    32'd0);
    chk("rst_wen",     {31'd0, WEN},     32'd0);
    chk("rst_wadd",    {29'd0, WADD},    32'd0);
    chk("rst_dataout", {16'd0, DATAOUT}, 32'd0);
    chk("rst_hi",      {16'd0, HI},      32'd0);
    chk("rst_divz",    {31'd0, DIVZ},    32'd0);

    issue(1'b0, 16'h1234, 16'h0100, 3'd5, 16'h3400, 16'h0012, 1'b0);
    chk("busy_run", {31'd0, BUSY}, 32'd1);
    wait_idle();
    issue(1'b0, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001, 16'hFFFE, 1'b0);
    wait_idle();
    issue(1'b1, 16'd1000, 16'd7, 3'd2, 16'h008E, 16'd6, 1'b0);
    wait_idle();
    issue(1'b1, 16'd5, 16'd9, 3'd3, 16'd0, 16'd5, 1'b0);
    wait_idle();
    issue(1'b1, 16'h0010, 16'h0010, 3'd0, 16'd1, 16'd0, 1'b0);
    wait_idle();
    issue(1'b1, 16'hBEEF, 16'h0000, 3'd7, 16'hFFFF, 16'hBEEF, 1'b1);
    wait_idle();
    chk("divz_held", {31'd0, DIVZ}, 32'd1);
    chk("hi_held",   {16'd0, HI},   32'h0000_BEEF);
    issue(1'b0, 16'd7, 16'd6, 3'd4, 16'd42, 16'd0, 1'b0);
    wait_idle();
    chk("divz_cleared", {31'd0, DIVZ}, 32'd0);

    // START pulses while busy must be dropped.
    issue(1'b0, 16'h00FF, 16'h0101, 3'd6, 16'hFFFF, 16'h0000, 1'b0);
    repeat (2) @(negedge CLK);
    OP = 1'b1; A = 16'hAAAA; B = 16'd3; DEST = 3'd0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("busy_ignore1", {31'd0, BUSY}, 32'd1);
    repeat (6) @(negedge CLK);
    OP = 1'b1; A = 16'h0001; B = 16'd1; DEST = 3'd3; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("busy_ignore2", {31'd0, BUSY}, 32'd1);
    wait_idle();
    repeat (25) @(negedge CLK);

    // Back-to-back: second write DW+2 cycles after the first.
    issue(1'b1, 16'hFFFF, 16'h0010, 3'd1, 16'h0FFF, 16'h000F, 1'b0);
    wait_idle();
    issue(1'b0, 16'h8000, 16'h0002, 3'd2, 16'h0000, 16'h0001, 1'b0);
    wait_idle();
    chk("b2b_gap", last_wen_cyc - prev_wen_cyc, DW + 2);

    // Reset during RUN aborts without a write.
    launch(1'b0, 16'h1111, 16'h0002, 3'd6);
    repeat (7) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_wen",  {31'd0, WEN},  32'd0);
    repeat (25) @(negedge CLK);
    issue(1'b0, 16'd3, 16'd4, 3'd5, 16'd12, 16'd0, 1'b0);
    wait_idle();

    repeat (3) @(negedge CLK);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
